// File: rtl/qeciphy_rx_framer.sv
`default_nettype none
// ============================================================================
// Module   : qeciphy_rx_framer
// Purpose  : Receive deframer for the QECIPHY link. Hunts for and holds frame
//            lock on the alignment pattern carried in each frame's status
//            word, checks a CRC-8 over the payload, and commits only good
//            frames into a first-word-fall-through FIFO. Remote link status
//            bits are extracted from good frames.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            i_rx_data, i_rx_valid    - aligned link words from byte aligner
//            o_data, o_valid, i_ready - user-side ready/valid payload stream
//            o_rx_rdy                 - frame lock held
//            o_remote_*               - remote status (pd bits gated by empty)
//            o_fap_missing, o_crc_mismatch, o_overflow - 1-cycle event pulses
//            o_drop_count             - saturating count of frames dropped
// Revision : 1.0 - initial release
// ============================================================================
module qeciphy_rx_framer #(
    parameter int         DATA_WIDTH    = 64,
    parameter int         PAYLOAD_WORDS = 7,
    parameter int         FIFO_DEPTH    = 64,
    parameter logic [7:0] FAP_BYTE      = 8'hBC,
    parameter int         LOCK_COUNT    = 3,
    parameter int         MISS_LIMIT    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_rx_rdy,
    output logic                  o_remote_rx_rdy,
    output logic                  o_remote_pd_req,
    output logic                  o_remote_pd_ack,
    output logic                  o_fap_missing,
    output logic                  o_crc_mismatch,
    output logic                  o_overflow,
    output logic [15:0]           o_drop_count
);

    localparam int c_AW   = $clog2(FIFO_DEPTH);
    localparam int c_PW_W = $clog2(PAYLOAD_WORDS + 1);
    localparam int c_GW   = $clog2(LOCK_COUNT + 1);
    localparam int c_MW   = $clog2(MISS_LIMIT + 1);

    localparam logic [c_PW_W-1:0] c_POS_LAST = c_PW_W'(PAYLOAD_WORDS);
    localparam logic [c_AW:0]     c_DEPTH    = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_AW:0]     c_PW       = (c_AW + 1)'(PAYLOAD_WORDS);
    localparam logic [c_GW-1:0]   c_LOCK     = c_GW'(LOCK_COUNT);
    localparam logic [c_MW-1:0]   c_MISS     = c_MW'(MISS_LIMIT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // CRC-8, poly 0x07, processed MSB first across the whole word.
    function automatic logic [7:0] crc8_word(input logic [7:0]            crc_in,
                                             input logic [DATA_WIDTH-1:0] data);
        logic [7:0] c;
        c = crc_in;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (c[7] ^ data[i]) begin
                c = {c[6:0], 1'b0} ^ 8'h07;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

    state_t              state_q, state_d;
    logic [c_PW_W-1:0]   pos_q, pos_d;
    logic [7:0]          crc_q, crc_d;
    logic [c_GW-1:0]     good_cnt_q, good_cnt_d;
    logic [c_MW-1:0]     miss_cnt_q, miss_cnt_d;
    logic                accept_q, accept_d;
    logic [c_AW:0]       spec_ptr_q, spec_ptr_d;
    logic [c_AW:0]       commit_ptr_q, commit_ptr_d;
    logic [c_AW:0]       rd_ptr_q, rd_ptr_d;
    logic                remote_rx_rdy_q, remote_rx_rdy_d;
    logic                remote_pd_req_q, remote_pd_req_d;
    logic                remote_pd_ack_q, remote_pd_ack_d;
    logic                fap_missing_q, fap_missing_d;
    logic                crc_mismatch_q, crc_mismatch_d;
    logic                overflow_q, overflow_d;
    logic [15:0]         drop_count_q, drop_count_d;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic          w_fap_ok;
    logic [7:0]    w_crc_rx;
    logic          w_status;
    logic [c_AW:0] w_count;
    logic          w_empty;
    logic          w_space_ok;
    logic          w_pop;
    logic          w_accept;
    logic          w_wr_en;
    logic [7:0]    w_crc_seed;

    assign w_fap_ok   = (i_rx_data[DATA_WIDTH-1 -: 8] == FAP_BYTE);
    assign w_crc_rx   = i_rx_data[DATA_WIDTH-9 -: 8];
    assign w_status   = (pos_q == c_POS_LAST);
    // Only committed words count as occupied; speculative words of the
    // in-flight frame live in space already reserved at its first word.
    assign w_count    = commit_ptr_q - rd_ptr_q;
    assign w_empty    = (w_count == '0);
    assign w_space_ok = ((c_DEPTH - w_count) >= c_PW);
    assign w_pop      = !w_empty && i_ready;
    // The accept decision is taken on the first payload word and held for
    // the rest of the frame.
    assign w_accept   = (pos_q == '0) ? w_space_ok : accept_q;
    assign w_wr_en    = i_rx_valid && (state_q == LOCKED) && !w_status && w_accept;
    assign w_crc_seed = (pos_q == '0) ? 8'hFF : crc_q;

    always_comb begin
        state_d         = state_q;
        pos_d           = pos_q;
        crc_d           = crc_q;
        good_cnt_d      = good_cnt_q;
        miss_cnt_d      = miss_cnt_q;
        accept_d        = accept_q;
        spec_ptr_d      = spec_ptr_q;
        commit_ptr_d    = commit_ptr_q;
        rd_ptr_d        = rd_ptr_q + ((c_AW + 1)'(w_pop));
        remote_rx_rdy_d = remote_rx_rdy_q;
        remote_pd_req_d = remote_pd_req_q;
        remote_pd_ack_d = remote_pd_ack_q;
        fap_missing_d   = 1'b0;
        crc_mismatch_d  = 1'b0;
        overflow_d      = 1'b0;
        drop_count_d    = drop_count_q;

        if (i_rx_valid) begin
            // Result is only meaningful on payload slots; pos 0 reseeds it.
            crc_d = crc8_word(w_crc_seed, i_rx_data);

            unique case (state_q)
                HUNT: begin
                    if (w_fap_ok) begin
                        state_d    = VERIFY;
                        good_cnt_d = c_GW'(1);
                        pos_d      = '0;
                    end
                end

                VERIFY: begin
                    if (w_status) begin
                        pos_d = '0;
                        if (w_fap_ok) begin
                            good_cnt_d = good_cnt_q + c_GW'(1);
                            if (good_cnt_q + c_GW'(1) == c_LOCK) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            state_d    = HUNT;
                            good_cnt_d = '0;
                        end
                    end else begin
                        pos_d = pos_q + c_PW_W'(1);
                    end
                end

                LOCKED: begin
                    if (!w_status) begin
                        pos_d = pos_q + c_PW_W'(1);
                        if (pos_q == '0) begin
                            accept_d = w_space_ok;
                            if (!w_space_ok) begin
                                overflow_d = 1'b1;
                                if (drop_count_q != 16'hFFFF) begin
                                    drop_count_d = drop_count_q + 16'd1;
                                end
                            end
                        end
                        if (w_wr_en) begin
                            spec_ptr_d = spec_ptr_q + (c_AW + 1)'(1);
                        end
                    end else begin
                        pos_d = '0;
                        if (w_fap_ok) begin
                            miss_cnt_d = '0;
                            if (crc_q == w_crc_rx) begin
                                // A dropped frame never advanced spec_ptr,
                                // so this commit is a no-op for it.
                                commit_ptr_d    = spec_ptr_q;
                                remote_rx_rdy_d = i_rx_data[0];
                                remote_pd_req_d = i_rx_data[1];
                                remote_pd_ack_d = i_rx_data[2];
                            end else begin
                                spec_ptr_d     = commit_ptr_q;
                                crc_mismatch_d = 1'b1;
                            end
                        end else begin
                            spec_ptr_d    = commit_ptr_q;
                            fap_missing_d = 1'b1;
                            if (miss_cnt_q + c_MW'(1) == c_MISS) begin
                                state_d         = HUNT;
                                miss_cnt_d      = '0;
                                good_cnt_d      = '0;
                                remote_rx_rdy_d = 1'b0;
                                remote_pd_req_d = 1'b0;
                                remote_pd_ack_d = 1'b0;
                            end else begin
                                miss_cnt_d = miss_cnt_q + c_MW'(1);
                            end
                        end
                    end
                end

                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= HUNT;
            pos_q           <= '0;
            crc_q           <= 8'hFF;
            good_cnt_q      <= '0;
            miss_cnt_q      <= '0;
            accept_q        <= 1'b0;
            spec_ptr_q      <= '0;
            commit_ptr_q    <= '0;
            rd_ptr_q        <= '0;
            remote_rx_rdy_q <= 1'b0;
            remote_pd_req_q <= 1'b0;
            remote_pd_ack_q <= 1'b0;
            fap_missing_q   <= 1'b0;
            crc_mismatch_q  <= 1'b0;
            overflow_q      <= 1'b0;
            drop_count_q    <= '0;
        end else begin
            state_q         <= state_d;
            pos_q           <= pos_d;
            crc_q           <= crc_d;
            good_cnt_q      <= good_cnt_d;
            miss_cnt_q      <= miss_cnt_d;
            accept_q        <= accept_d;
            spec_ptr_q      <= spec_ptr_d;
            commit_ptr_q    <= commit_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            remote_rx_rdy_q <= remote_rx_rdy_d;
            remote_pd_req_q <= remote_pd_req_d;
            remote_pd_ack_q <= remote_pd_ack_d;
            fap_missing_q   <= fap_missing_d;
            crc_mismatch_q  <= crc_mismatch_d;
            overflow_q      <= overflow_d;
            drop_count_q    <= drop_count_d;
        end
    end

    // Payload storage; contents need no reset because reads are gated by
    // the committed count.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem[spec_ptr_q[c_AW-1:0]] <= i_rx_data;
        end
    end

    assign o_data          = w_empty ? '0 : mem[rd_ptr_q[c_AW-1:0]];
    assign o_valid         = !w_empty;
    assign o_rx_rdy        = (state_q == LOCKED);
    assign o_remote_rx_rdy = remote_rx_rdy_q;
    assign o_remote_pd_req = remote_pd_req_q && w_empty;
    assign o_remote_pd_ack = remote_pd_ack_q && w_empty;
    assign o_fap_missing   = fap_missing_q;
    assign o_crc_mismatch  = crc_mismatch_q;
    assign o_overflow      = overflow_q;
    assign o_drop_count    = drop_count_q;

endmodule
`default_nettype wire
